// File: rtl/crc16_dual_port.sv
// -----------------------------------------------------------------------------
// crc16_dual_port
//
// Bit-serial CRC-16/CCITT-FALSE engine shared by two clients: the seal register
// (SEAL port) and the CPU CRC peripheral (CPU port). Each port owns its own
// 16-bit CRC state and a one-byte holding slot. A single 8-cycle shift datapath
// is time-shared between the ports one whole byte at a time, so traffic on one
// port never disturbs the running CRC of the other.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   seal_byte    in   [7:0]  data byte from the seal register
//   seal_feed    in   pulse: enqueue seal_byte
//   seal_init    in   pulse: seal CRC state <= INIT
//   seal_busy    out  seal port not ready / seal_value not final
//   seal_value   out  [15:0] seal CRC state
//   cpu_byte     in   [7:0]  data byte from CPU peripheral write
//   cpu_feed     in   pulse: enqueue cpu_byte
//   cpu_init     in   pulse: CPU CRC state <= INIT, clears cpu_overrun
//   cpu_busy     out  CPU port not ready / cpu_value not final
//   cpu_value    out  [15:0] CPU CRC state
//   cpu_overrun  out  sticky: a CPU feed was dropped because the port was busy
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module crc16_dual_port #(
   parameter logic [15:0] POLY = 16'h1021,
   parameter logic [15:0] INIT = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  seal_byte,
   input  logic        seal_feed,
   input  logic        seal_init,
   output logic        seal_busy,
   output logic [15:0] seal_value,
   input  logic [7:0]  cpu_byte,
   input  logic        cpu_feed,
   input  logic        cpu_init,
   output logic        cpu_busy,
   output logic [15:0] cpu_value,
   output logic        cpu_overrun
);

   typedef enum logic {
      OWN_SEAL = 1'b0,
      OWN_CPU  = 1'b1
   } owner_t;

   // Per-port CRC state and holding slot
   logic [15:0] r_seal_state;
   logic [15:0] r_cpu_state;
   logic        r_seal_pend;
   logic        r_cpu_pend;
   logic [7:0]  r_seal_pbyte;
   logic [7:0]  r_cpu_pbyte;
   logic        r_cpu_overrun;

   // Shared shift datapath
   logic        r_active;
   owner_t      r_owner;
   logic [7:0]  r_sh;
   logic [2:0]  r_cnt;

   logic        w_seal_inflight;
   logic        w_cpu_inflight;
   logic        w_seal_accept;
   logic        w_cpu_accept;
   logic        w_cpu_drop;
   logic        w_seal_req;
   logic        w_cpu_req;
   logic        w_grant_seal;
   logic        w_grant_cpu;
   logic        w_abort;
   logic        w_last_bit;

   // One MSB-first CRC step: shift the state left by one, folding in the data bit.
   function automatic logic [15:0] crc_shift(input logic [15:0] st, input logic din);
      crc_shift = {st[14:0], 1'b0} ^ ((st[15] ^ din) ? POLY : 16'h0000);
   endfunction

   assign w_seal_inflight = r_active && (r_owner == OWN_SEAL);
   assign w_cpu_inflight  = r_active && (r_owner == OWN_CPU);

   // An init in the same cycle empties the slot and aborts any in-flight byte of
   // that port, so a simultaneous feed is always taken as the first byte of the
   // new CRC.
   assign w_seal_accept = seal_feed && (seal_init || (!r_seal_pend && !w_seal_inflight));
   assign w_cpu_accept  = cpu_feed  && (cpu_init  || (!r_cpu_pend  && !w_cpu_inflight));
   assign w_cpu_drop    = cpu_feed && !w_cpu_accept;

   // A pending byte that is being wiped by init this cycle must not be granted.
   assign w_seal_req   = r_seal_pend && !seal_init;
   assign w_cpu_req    = r_cpu_pend  && !cpu_init;
   assign w_grant_seal = !r_active && w_seal_req;
   assign w_grant_cpu  = !r_active && !w_seal_req && w_cpu_req;

   assign w_abort    = (w_seal_inflight && seal_init) || (w_cpu_inflight && cpu_init);
   assign w_last_bit = (r_cnt == 3'd7);

   // Control and CRC state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seal_state  <= INIT;
         r_cpu_state   <= INIT;
         r_seal_pend   <= 1'b0;
         r_cpu_pend    <= 1'b0;
         r_cpu_overrun <= 1'b0;
         r_active      <= 1'b0;
         r_owner       <= OWN_SEAL;
         r_cnt         <= 3'd0;
      end else begin
         // Holding slots
         if (seal_init) begin
            r_seal_pend <= w_seal_accept;
         end else if (w_seal_accept) begin
            r_seal_pend <= 1'b1;
         end else if (w_grant_seal) begin
            r_seal_pend <= 1'b0;
         end

         if (cpu_init) begin
            r_cpu_pend <= w_cpu_accept;
         end else if (w_cpu_accept) begin
            r_cpu_pend <= 1'b1;
         end else if (w_grant_cpu) begin
            r_cpu_pend <= 1'b0;
         end

         if (cpu_init) begin
            r_cpu_overrun <= 1'b0;
         end else if (w_cpu_drop) begin
            r_cpu_overrun <= 1'b1;
         end

         // Arbitration happens only while idle, so the completing edge of one
         // byte is never also a grant edge.
         if (w_grant_seal || w_grant_cpu) begin
            r_active <= 1'b1;
            r_owner  <= w_grant_seal ? OWN_SEAL : OWN_CPU;
            r_cnt    <= 3'd0;
         end else if (r_active) begin
            if (w_abort || w_last_bit) begin
               r_active <= 1'b0;
            end
            r_cnt <= r_cnt + 3'd1;
         end

         // CRC states: init wins over the shift of an in-flight byte
         if (seal_init) begin
            r_seal_state <= INIT;
         end else if (w_seal_inflight) begin
            r_seal_state <= crc_shift(r_seal_state, r_sh[7]);
         end

         if (cpu_init) begin
            r_cpu_state <= INIT;
         end else if (w_cpu_inflight) begin
            r_cpu_state <= crc_shift(r_cpu_state, r_sh[7]);
         end
      end
   end

   // Byte datapath: contents are only meaningful while the matching flag is set
   always_ff @(posedge clk) begin
      if (w_seal_accept) begin
         r_seal_pbyte <= seal_byte;
      end
      if (w_cpu_accept) begin
         r_cpu_pbyte <= cpu_byte;
      end
      if (w_grant_seal) begin
         r_sh <= r_seal_pbyte;
      end else if (w_grant_cpu) begin
         r_sh <= r_cpu_pbyte;
      end else if (r_active) begin
         r_sh <= {r_sh[6:0], 1'b0};
      end
   end

   // Busy includes same-cycle feed/init: the seal register samples busy the
   // cycle right after it pulses feed.
   assign seal_busy   = seal_feed | seal_init | r_seal_pend | w_seal_inflight;
   assign cpu_busy    = cpu_feed  | cpu_init  | r_cpu_pend  | w_cpu_inflight;
   assign seal_value  = r_seal_state;
   assign cpu_value   = r_cpu_state;
   assign cpu_overrun = r_cpu_overrun;

endmodule

// File: tb/tb_crc16_dual_port.sv
`timescale 1ns/1ps

module tb_crc16_dual_port;

   localparam int LIM = 60;

   logic        clk;
   logic        rst_n;
   logic [7:0]  seal_byte;
   logic        seal_feed;
   logic        seal_init;
   logic        seal_busy;
   logic [15:0] seal_value;
   logic [7:0]  cpu_byte;
   logic        cpu_feed;
   logic        cpu_init;
   logic        cpu_busy;
   logic [15:0] cpu_value;
   logic        cpu_overrun;

   int n_checks = 0;
   int n_err    = 0;

   logic [15:0] seal_model;
   logic [15:0] cpu_model;

   crc16_dual_port dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seal_byte   (seal_byte),
      .seal_feed   (seal_feed),
      .seal_init   (seal_init),
      .seal_busy   (seal_busy),
      .seal_value  (seal_value),
      .cpu_byte    (cpu_byte),
      .cpu_feed    (cpu_feed),
      .cpu_init    (cpu_init),
      .cpu_busy    (cpu_busy),
      .cpu_value   (cpu_value),
      .cpu_overrun (cpu_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte-wise CRC-16/CCITT-FALSE reference (data XORed into the top byte)
   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c ^ {b, 8'h00};
      for (int i = 0; i < 8; i++) begin
         r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to 1ns after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      while ((seal_busy || cpu_busy) && k < LIM) begin
         step();
         #1;
         k++;
      end
      if (k >= LIM) chk(tag, 32'({seal_busy, cpu_busy}), 32'd0);
   endtask

   task automatic feed_cpu(input logic [7:0] b);
      int k;
      k = 0;
      while (cpu_busy && k < LIM) begin
         step();
         #1;
         k++;
      end
      if (k >= LIM) chk("cpu_feed_wait", 32'(cpu_busy), 32'd0);
      cpu_byte = b;
      cpu_feed = 1'b1;
      cpu_model = crc_byte(cpu_model, b);
      step();
      cpu_feed = 1'b0;
      #1;
   endtask

   initial begin
      logic [7:0] msg [9];
      int si, ci, cyc, ncoll, ts, tc, n;
      logic do_s, do_c;

      msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      rst_n = 1'b0;
      seal_byte = 8'h00; seal_feed = 1'b0; seal_init = 1'b0;
      cpu_byte  = 8'h00; cpu_feed  = 1'b0; cpu_init  = 1'b0;
      seal_model = 16'hFFFF;
      cpu_model  = 16'hFFFF;

      // ---------------- reset state
      repeat (3) step();
      chk("rst_seal_value", 32'(seal_value), 32'h0000FFFF);
      chk("rst_cpu_value", 32'(cpu_value), 32'h0000FFFF);
      chk("rst_seal_busy", 32'(seal_busy), 32'd0);
      chk("rst_cpu_busy", 32'(cpu_busy), 32'd0);
      chk("rst_overrun", 32'(cpu_overrun), 32'd0);
      rst_n = 1'b1;
      repeat (20) step();
      chk("idle_seal_value", 32'(seal_value), 32'h0000FFFF);
      chk("idle_cpu_value", 32'(cpu_value), 32'h0000FFFF);
      chk("idle_seal_busy", 32'(seal_busy), 32'd0);
      chk("idle_cpu_busy", 32'(cpu_busy), 32'd0);
      chk("idle_overrun", 32'(cpu_overrun), 32'd0);

      // ---------------- SEAL init then single 0x00 byte, latency profile
      seal_init = 1'b1;
      step();
      seal_init = 1'b0;
      seal_byte = 8'h00;
      seal_feed = 1'b1;
      #1;
      chk("seal_busy_T0", 32'(seal_busy), 32'd1);
      for (int i = 1; i <= 10; i++) begin
         step();
         seal_feed = 1'b0;
         #1;
         if (i < 10) chk($sformatf("seal_busy_T%0d", i), 32'(seal_busy), 32'd1);
         else        chk("seal_busy_T10", 32'(seal_busy), 32'd0);
      end
      chk("seal_crc_00", 32'(seal_value), 32'h0000E1F0);
      chk("cpu_untouched", 32'(cpu_value), 32'h0000FFFF);

      // ---------------- CPU "123456789"
      cpu_model = 16'hFFFF;
      for (int i = 0; i < 9; i++) feed_cpu(msg[i]);
      wait_idle("cpu_check_timeout");
      chk("cpu_check_29B1", 32'(cpu_value), 32'h000029B1);
      chk("cpu_check_model", 32'(cpu_value), 32'(cpu_model));

      // ---------------- interleaved traffic with random collisions
      seal_init = 1'b1;
      cpu_init  = 1'b1;
      step();
      seal_init = 1'b0;
      cpu_init  = 1'b0;
      #1;
      seal_model = 16'hFFFF;
      cpu_model  = 16'hFFFF;
      si = 0; ci = 0; cyc = 0; ncoll = 0;
      while ((si < 9 || ci < 5) && cyc < 2000) begin
         do_s = (si < 9) && !seal_busy && ($urandom_range(0, 2) != 0);
         do_c = (ci < 5) && !cpu_busy && (do_s || ($urandom_range(0, 2) == 0));
         if (do_s) begin
            seal_byte = 8'(si);
            seal_feed = 1'b1;
            seal_model = crc_byte(seal_model, 8'(si));
            si++;
         end
         if (do_c) begin
            cpu_byte = msg[ci];
            cpu_feed = 1'b1;
            cpu_model = crc_byte(cpu_model, msg[ci]);
            ci++;
         end
         if (do_s && do_c) ncoll++;
         step();
         seal_feed = 1'b0;
         cpu_feed  = 1'b0;
         #1;
         cyc++;
      end
      if (cyc >= 2000) chk("interleave_progress", 32'(si + ci), 32'd14);
      for (int i = 5; i < 9; i++) feed_cpu(msg[i]);
      wait_idle("interleave_timeout");
      chk("interleave_cpu_29B1", 32'(cpu_value), 32'h000029B1);
      chk("interleave_seal_model", 32'(seal_value), 32'(seal_model));
      chk("interleave_overrun", 32'(cpu_overrun), 32'd0);

      // ---------------- simultaneous feed: SEAL first, CPU 9 cycles later
      seal_byte = 8'hA5; seal_feed = 1'b1;
      cpu_byte  = 8'h5A; cpu_feed  = 1'b1;
      seal_model = crc_byte(seal_model, 8'hA5);
      cpu_model  = crc_byte(cpu_model, 8'h5A);
      ts = -1; tc = -1;
      for (int i = 1; i <= 30; i++) begin
         step();
         seal_feed = 1'b0;
         cpu_feed  = 1'b0;
         #1;
         if (!seal_busy && ts < 0) ts = i;
         if (!cpu_busy && tc < 0) tc = i;
      end
      chk("simul_seal_lat", 32'(ts), 32'd10);
      chk("simul_cpu_lat", 32'(tc), 32'd19);
      chk("simul_gap", 32'(tc - ts), 32'd9);
      chk("simul_seal_value", 32'(seal_value), 32'(seal_model));
      chk("simul_cpu_value", 32'(cpu_value), 32'(cpu_model));

      // ---------------- CPU overrun
      cpu_init = 1'b1;
      step();
      cpu_init = 1'b0;
      #1;
      cpu_model = 16'hFFFF;
      feed_cpu(msg[0]);
      step();
      step();
      cpu_byte = 8'h99;
      cpu_feed = 1'b1;
      #1;
      chk("overrun_before", 32'(cpu_overrun), 32'd0);
      step();
      cpu_feed = 1'b0;
      #1;
      chk("overrun_set", 32'(cpu_overrun), 32'd1);
      for (int i = 1; i < 9; i++) feed_cpu(msg[i]);
      wait_idle("overrun_timeout");
      chk("overrun_crc_29B1", 32'(cpu_value), 32'h000029B1);
      chk("overrun_sticky", 32'(cpu_overrun), 32'd1);
      cpu_init = 1'b1;
      step();
      cpu_init = 1'b0;
      #1;
      cpu_model = 16'hFFFF;
      chk("overrun_cleared", 32'(cpu_overrun), 32'd0);
      chk("cpu_init_value", 32'(cpu_value), 32'h0000FFFF);

      // ---------------- seal_init at cnt==3 with a CPU byte queued
      seal_init = 1'b1;
      step();
      seal_init = 1'b0;
      seal_byte = 8'h12; seal_feed = 1'b1;
      cpu_byte  = 8'h34; cpu_feed  = 1'b1;
      cpu_model = crc_byte(cpu_model, 8'h34);
      step();
      seal_feed = 1'b0;
      cpu_feed  = 1'b0;
      repeat (4) step();
      seal_init = 1'b1;
      #1;
      chk("abort_busy_init_cycle", 32'(seal_busy), 32'd1);
      step();
      seal_init = 1'b0;
      #1;
      seal_model = 16'hFFFF;
      chk("abort_seal_value", 32'(seal_value), 32'(seal_model));
      chk("abort_seal_busy", 32'(seal_busy), 32'd0);
      chk("abort_cpu_busy", 32'(cpu_busy), 32'd1);
      n = 0;
      while (cpu_busy && n < LIM) begin
         step();
         #1;
         n++;
      end
      chk("abort_cpu_lat", 32'(n), 32'd9);
      chk("abort_cpu_value", 32'(cpu_value), 32'(cpu_model));
      chk("abort_seal_hold", 32'(seal_value), 32'h0000FFFF);

      // ---------------- asynchronous reset in the middle of a shift
      feed_cpu(8'h77);
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_cpu_value", 32'(cpu_value), 32'h0000FFFF);
      chk("midrst_cpu_busy", 32'(cpu_busy), 32'd0);
      step();
      rst_n = 1'b1;
      repeat (12) step();
      chk("midrst_after_value", 32'(cpu_value), 32'h0000FFFF);
      chk("midrst_after_busy", 32'(cpu_busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
